// File: rtl/countdown_timer_ms_if.sv
// ============================================================================
// Module   : countdown_timer_ms_if
// Purpose  : Control/status bundle between game FSM, timer and display logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_timer_ms_if #(
   parameter int VAL_W = 8
);
   logic             i_load;
   logic [VAL_W-1:0] i_init;
   logic             i_en;
   logic [1:0]       i_mode;
   logic [VAL_W-1:0] o_val;
   logic             o_tick;
   logic             o_timeout;
   logic             o_expired;
   logic             o_running;
   logic             o_warn;

   modport master (
      output i_load, i_init, i_en, i_mode,
      input  o_val, o_tick, o_timeout, o_expired, o_running, o_warn
   );

   modport slave (
      input  i_load, i_init, i_en, i_mode,
      output o_val, o_tick, o_timeout, o_expired, o_running, o_warn
   );
endinterface

`default_nettype wire

// File: rtl/countdown_timer_ms.sv
// ============================================================================
// Module   : countdown_timer_ms
// Purpose  : Multi-mode interval timer (one-shot, auto-reload, count-up).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer_ms #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 1,
   parameter int VAL_W    = 8,
   parameter int WARN_TH  = 3
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   countdown_timer_ms_if.slave bus
);

   localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [VAL_W-1:0] ONE      = VAL_W'(1);
   localparam logic [VAL_W:0]   WARN_LIM = (VAL_W + 1)'(WARN_TH);

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;
   localparam logic [1:0] MODE_UP      = 2'b10;

   generate
      if (TICK_DIV < 2) begin : g_div_check
         $error("countdown_timer_ms: CLK_FREQ/TICK_HZ must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [PRE_W-1:0] pre, pre_nx;
   logic [VAL_W-1:0] val, val_nx;
   logic [VAL_W-1:0] reload, reload_nx;
   logic [1:0]       mode, mode_nx;
   logic             tick, tick_nx;
   logic             timeout, timeout_nx;
   logic             expired, expired_nx;

   logic [1:0]       load_mode;
   logic [VAL_W-1:0] val_inc;
   logic [VAL_W-1:0] val_dec;

   // Mode 11 is folded onto one-shot at load so the rest of the logic sees three modes.
   assign load_mode = (bus.i_mode == 2'b11) ? MODE_ONESHOT : bus.i_mode;
   assign val_inc   = val + ONE;
   assign val_dec   = val - ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pre     <= '0;
         val     <= '0;
         reload  <= '0;
         mode    <= MODE_ONESHOT;
         tick    <= 1'b0;
         timeout <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nx;
         pre     <= pre_nx;
         val     <= val_nx;
         reload  <= reload_nx;
         mode    <= mode_nx;
         tick    <= tick_nx;
         timeout <= timeout_nx;
         expired <= expired_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      pre_nx     = pre;
      val_nx     = val;
      reload_nx  = reload;
      mode_nx    = mode;
      tick_nx    = 1'b0;
      timeout_nx = 1'b0;
      expired_nx = expired;

      if (bus.i_load) begin
         pre_nx     = '0;
         expired_nx = 1'b0;
         mode_nx    = load_mode;
         reload_nx  = bus.i_init;
         val_nx     = (load_mode == MODE_UP) ? '0 : bus.i_init;
         if (bus.i_init == '0) begin
            state_nx   = DONE;
            expired_nx = 1'b1;
         end else begin
            state_nx = bus.i_en ? RUN : PAUSE;
         end
      end else if (state == RUN || state == PAUSE) begin
         // The resume edge itself counts, so a pause of P cycles costs exactly P cycles.
         if (!bus.i_en) begin
            state_nx = PAUSE;
         end else begin
            state_nx = RUN;
            if (pre != PRE_MAX) begin
               pre_nx = pre + PRE_ONE;
            end else begin
               pre_nx  = '0;
               tick_nx = 1'b1;
               case (mode)
                  MODE_RELOAD: begin
                     if (val == ONE) begin
                        val_nx     = reload;
                        timeout_nx = 1'b1;
                     end else begin
                        val_nx = val_dec;
                     end
                  end
                  MODE_UP: begin
                     val_nx = val_inc;
                     if (val_inc == reload) begin
                        timeout_nx = 1'b1;
                        expired_nx = 1'b1;
                        state_nx   = DONE;
                     end
                  end
                  default: begin
                     val_nx = val_dec;
                     if (val == ONE) begin
                        timeout_nx = 1'b1;
                        expired_nx = 1'b1;
                        state_nx   = DONE;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign bus.o_val     = val;
   assign bus.o_tick    = tick;
   assign bus.o_timeout = timeout;
   assign bus.o_expired = expired;
   assign bus.o_running = (state == RUN);
   assign bus.o_warn    = (mode != MODE_UP) && (state == RUN || state == PAUSE) &&
                          (val != '0) && ({1'b0, val} <= WARN_LIM);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ms.sv
// ============================================================================
// Module   : tb_countdown_timer_ms
// Purpose  : Randomised scoreboard bench for countdown_timer_ms (TICK_DIV=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer_ms;

   localparam int CLK_FREQ = 10;
   localparam int TICK_HZ  = 1;
   localparam int DIV      = CLK_FREQ / TICK_HZ;
   localparam int VAL_W    = 8;
   localparam int WARN_TH  = 3;

   logic clk;
   logic rst_n;

   countdown_timer_ms_if #(.VAL_W(VAL_W)) bus ();

   countdown_timer_ms #(
      .CLK_FREQ(CLK_FREQ),
      .TICK_HZ (TICK_HZ),
      .VAL_W   (VAL_W),
      .WARN_TH (WARN_TH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int val;
      int timeout;
      int expired;
   } ev_t;

   ev_t q[$];

   int checks   = 0;
   int failures = 0;
   int edge_no  = 0;

   // Reference model: value and elapsed enabled cycles since the last tick.
   bit m_active, m_up, m_rl, m_expired, m_timeout, m_running;
   int m_val, m_target, m_elapsed;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, edge_no, act, exp);
      end
   endfunction

   function automatic void reset_model();
      m_active  = 0; m_up = 0; m_rl = 0;
      m_expired = 0; m_timeout = 0; m_running = 0;
      m_val     = 0; m_target = 0; m_elapsed = 0;
   endfunction

   function automatic void model_edge(bit ld, int ini, bit en, int md);
      m_timeout = 0;
      if (ld) begin
         m_up      = (md == 2);
         m_rl      = (md == 1);
         m_target  = ini;
         m_val     = m_up ? 0 : ini;
         m_elapsed = 0;
         m_active  = (ini != 0);
         m_expired = (ini == 0);
         m_running = m_active && en;
      end else if (m_active) begin
         m_running = en;
         if (en) begin
            m_elapsed++;
            if (m_elapsed == DIV) begin
               m_elapsed = 0;
               if (m_up) begin
                  m_val++;
                  if (m_val == m_target) begin
                     m_timeout = 1; m_expired = 1; m_active = 0; m_running = 0;
                  end
               end else if (m_rl && m_val == 1) begin
                  m_val     = m_target;
                  m_timeout = 1;
               end else begin
                  m_val--;
                  if (m_val == 0) begin
                     m_timeout = 1; m_expired = 1; m_active = 0; m_running = 0;
                  end
               end
               q.push_back('{edge_no, m_val, int'(m_timeout), int'(m_expired)});
            end
         end
      end
   endfunction

   task automatic cycle(input bit ld, input int ini, input bit en, input int md);
      bus.i_load = ld;
      bus.i_init = ini[VAL_W-1:0];
      bus.i_en   = en;
      bus.i_mode = md[1:0];
      @(posedge clk);
      edge_no++;
      model_edge(ld, ini, en, md);
      #1;
   endtask

   task automatic apply_reset(input int n);
      #1;
      rst_n      = 1'b0;
      bus.i_load = 1'b0;
      bus.i_en   = 1'b0;
      reset_model();
      q.delete();
      repeat (n) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: pops a scoreboard entry whenever a tick is presented or due.
   always @(negedge clk) begin
      ev_t e;
      if (bus.o_tick || (q.size() > 0 && q[0].cyc == edge_no)) begin
         if (q.size() == 0 || q[0].cyc != edge_no) begin
            chk("tick_unexpected", int'(bus.o_tick), 0);
         end else begin
            e = q.pop_front();
            chk("tick_present", int'(bus.o_tick), 1);
            chk("tick_val", int'(bus.o_val), e.val);
            chk("tick_timeout", int'(bus.o_timeout), e.timeout);
            chk("tick_expired", int'(bus.o_expired), e.expired);
         end
      end
      chk("val", int'(bus.o_val), m_val);
      chk("timeout", int'(bus.o_timeout), int'(m_timeout));
      chk("expired", int'(bus.o_expired), int'(m_expired));
      chk("running", int'(bus.o_running), int'(m_running));
      chk("warn", int'(bus.o_warn), int'(m_active && !m_up && m_val > 0 && m_val <= WARN_TH));
   end

   int r;

   initial begin
      rst_n      = 1'b0;
      bus.i_load = 1'b0;
      bus.i_init = '0;
      bus.i_en   = 1'b0;
      bus.i_mode = 2'b00;
      reset_model();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Enable alone must not start from IDLE.
      repeat (5) cycle(0, 7, 1, 0);

      // One-shot down from 3.
      cycle(1, 3, 1, 0);
      repeat (40) cycle(0, 0, 1, 0);

      // Auto-reload from 2.
      cycle(1, 2, 1, 1);
      repeat (65) cycle(0, 0, 1, 1);

      // Count-up to 4, then enable toggling in DONE.
      cycle(1, 4, 1, 2);
      repeat (45) cycle(0, 0, 1, 2);
      repeat (20) cycle(0, 9, $urandom_range(0, 1) != 0, 0);

      // Pause of 7 cycles with four enabled cycles already elapsed.
      cycle(1, 5, 1, 0);
      repeat (14) cycle(0, 0, 1, 0);
      repeat (7) cycle(0, 0, 0, 0);
      repeat (30) cycle(0, 0, 1, 0);

      // Load coinciding with a wrap, then a zero load.
      cycle(1, 5, 1, 0);
      repeat (9) cycle(0, 0, 1, 0);
      cycle(1, 9, 1, 0);
      repeat (5) cycle(0, 0, 1, 0);
      cycle(1, 0, 1, 0);
      repeat (5) cycle(0, 0, 1, 0);

      // Mode 11 behaves as one-shot; load while paused.
      cycle(1, 2, 0, 3);
      repeat (4) cycle(0, 0, 0, 3);
      repeat (25) cycle(0, 0, 1, 3);

      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 199);
         if (r == 0)
            apply_reset(2);
         else if (r < 6)
            cycle(1, $urandom_range(0, 12), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
         else
            cycle(0, $urandom_range(0, 255), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
      end

      // Reset in the middle of a count; enable alone must not restart it.
      cycle(1, 6, 1, 0);
      repeat (15) cycle(0, 0, 1, 0);
      apply_reset(2);
      repeat (30) cycle(0, 0, 1, 0);

      @(negedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/countdown_timer_ms.md
# countdown_timer_ms

Parametrised multi-mode interval timer, the general-purpose successor to the game's single-channel second counter. Provides one-shot countdown, auto-reload countdown and count-up-to-target modes with configurable tick rate, value width and warning threshold. Sits between the game-control FSM (load/enable) and the seven-segment display/buzzer logic (value, warning, timeout).

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 1, tick rate in Hz; TICK_DIV = CLK_FREQ/TICK_HZ, must be >= 2 (elaboration error otherwise)
- VAL_W, 8, width of count value
- WARN_TH, 3, warning threshold (down modes), 0 disables warning

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_load  in  1  load pulse; latches i_init and i_mode, clears prescaler
- i_init  in  VAL_W  start value (down modes) or target (up mode)
- i_en  in  1  run enable: 1 counts, 0 pauses
- i_mode  in  2  00 one-shot down, 01 auto-reload down, 10 count-up to target, 11 treated as 00
- o_val  out  VAL_W  current count
- o_tick  out  1  one-cycle pulse on every prescaler wrap
- o_timeout  out  1  one-cycle pulse when the terminal value is reached
- o_expired  out  1  sticky done flag, cleared only by load or reset
- o_running  out  1  high in RUN state
- o_warn  out  1  down mode, state RUN or PAUSE, 0 < o_val <= WARN_TH

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset -> IDLE, all outputs 0, prescaler 0, latched mode 00, reload 0.
- Latched mode and reload register change only on i_load; i_mode/i_init ignored otherwise.
- i_load (any state, highest priority, overrides a coincident tick): prescaler <= 0, o_expired <= 0, o_timeout <= 0; o_val <= 0 in up mode else i_init; reload <= i_init.
  - i_init == 0: -> DONE, o_expired <= 1, no o_timeout pulse.
  - else -> RUN if i_en else PAUSE.
- RUN: on each edge with i_en = 1 prescaler increments, wraps at TICK_DIV-1 to 0. i_en = 0 -> PAUSE, prescaler held.
- PAUSE: prescaler and o_val frozen; i_en = 1 -> RUN (resume from held prescaler value, no lost partial tick).
- On wrap (prescaler == TICK_DIV-1, RUN, i_en = 1): o_tick <= 1, then
  - one-shot down: o_val-1; if o_val was 1: o_timeout <= 1, o_expired <= 1, -> DONE.
  - auto-reload down: if o_val was 1: o_val <= reload, o_timeout <= 1, stay RUN, o_expired stays 0; else o_val-1.
  - count-up: o_val+1; if o_val+1 == reload: o_timeout <= 1, o_expired <= 1, -> DONE.
- DONE: o_val held, prescaler held, i_en ignored; only i_load leaves. IDLE likewise leaves only on i_load.
- Arithmetic unsigned modulo 2^VAL_W; no value ever wraps below 0 or past target.

## Timing
- All outputs registered except o_warn (decoded from registered state/o_val, no path from inputs).
- Load at edge k with i_en held high: first o_val change and o_tick at edge k+TICK_DIV; subsequent ticks every TICK_DIV enabled cycles.
- o_timeout and o_expired rise at the same edge as the terminal o_val update; o_timeout high exactly one cycle.
- Pause of P cycles delays every later tick by exactly P cycles.
- Reset asserted mid-count: immediate return to reset values; no pulse emitted on release.

## Test plan
- CLK_FREQ=10, TICK_HZ=1, mode 00, i_init=3, i_en=1 -> o_val 3,2,1,0 at edges k+10,k+20,k+30; o_timeout one cycle at k+30; o_expired stays 1; o_warn high while o_val in 3..1.
- Mode 01, i_init=2 -> o_val 2,1,2,1,... with o_timeout every 20 cycles, o_expired never set.
- Mode 10, i_init=4 -> o_val 0,1,2,3,4, DONE at 4, o_warn never set; further i_en toggling leaves o_val=4.
- Mode 00, i_init=5, drop i_en for 7 cycles at prescaler=4 -> next decrement 17 cycles after previous tick, o_running low during pause.
- i_load coincident with wrap, i_init=9 -> o_val=9, no tick or timeout that cycle; i_init=0 load -> DONE, o_expired=1, no o_timeout.
- rst_n low mid-count -> o_val=0, IDLE, all flags 0; i_en alone does not start counting.
